// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file, bypassed operand fetch and pending-write scoreboard
module operand_fetch #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_en,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [DW-1:0]       op_a,
    output logic [DW-1:0]       op_b,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [DW-1:0]       wb_data,
    output logic [(1<<AW)-1:0]  pending
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0]   regs [NREG];
    logic [DW-1:0]   src1_val;
    logic [DW-1:0]   src2_val;
    logic            src1_ok;
    logic            src2_ok;
    logic            dst_ok;
    logic            slot_free;
    logic            accept;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    // Operand values with same-cycle write-back bypass; R0 is never written so it reads zero
    always_comb begin
        src1_val = regs[rs1_addr];
        src2_val = regs[rs2_addr];
        if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) src1_val = wb_data;
        if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) src2_val = wb_data;
    end

    // Hazard checks: a pending source or destination stalls unless its write-back lands this cycle
    always_comb begin
        src1_ok   = !pending[rs1_addr] || (wb_en && (wb_addr == rs1_addr));
        src2_ok   = !pending[rs2_addr] || (wb_en && (wb_addr == rs2_addr));
        dst_ok    = !rd_en || (rd_addr == '0) || !pending[rd_addr]
                    || (wb_en && (wb_addr == rd_addr));
        slot_free = !op_valid || op_ready;
        req_ready = reset && src1_ok && src2_ok && dst_ok && slot_free;
        accept    = req_valid && req_ready;
    end

    // Scoreboard masks; the set mask is OR'd after clearing so a same-index set wins
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_en) clr_mask = NREG'(1) << wb_addr;
        if (accept && rd_en && (rd_addr != '0)) set_mask = NREG'(1) << rd_addr;
    end

    // Register file write port; writes to R0 are discarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pending-write scoreboard
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clr_mask) | set_mask;
    end

    // Output entry: load on accept, hold while stalled, drop valid on drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= src1_val;
            op_b     <= src2_val;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic        rd_en = 1'b0;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [15:0] op_a, op_b;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    operand_fetch #(.DW(16), .AW(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_en(rd_en),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consume pops one expected operand pair
    always @(negedge clk) begin
        if (reset && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_op actual=%h expected=none", {op_a, op_b});
            end else begin
                chk("op_pair", {op_a, op_b}, exp_q.pop_front());
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, then push the expected pair
    task automatic issue(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] rd,
                         input logic en, input logic [15:0] ea, input logic [15:0] eb);
        bit done = 0;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd; rd_en = en; req_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back({ea, eb});
                done = 1;
            end
            step();
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        req_valid = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_op_ab", {op_a, op_b}, 0);
        step();
        reset = 1'b1;
        step();

        // Write R3 then read it; check 1-cycle latency
        wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
        step();
        wb_en = 0;
        issue(3, 0, 0, 0, 16'h1234, 16'h0000);
        @(negedge clk);
        chk("latency_valid", op_valid, 1);
        step();

        // Same-cycle bypass of write-back into source read
        wb_en = 1; wb_addr = 5; wb_data = 16'hBEEF;
        issue(5, 3, 0, 0, 16'hBEEF, 16'h1234);
        wb_en = 0;

        // RAW stall on pending R2, released by write-back
        issue(1, 0, 2, 1, 16'h0000, 16'h0000);
        chk("pend_set", pending, 8'h04);
        rs1_addr = 2; rs2_addr = 0; rd_en = 0; req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("raw_stall_ready", req_ready, 0);
            chk("raw_stall_pend", pending[2], 1);
            step();
        end
        wb_en = 1; wb_addr = 2; wb_data = 16'h00AA;
        @(negedge clk);
        chk("raw_release_ready", req_ready, 1);
        if (req_ready) exp_q.push_back({16'h00AA, 16'h0000});
        step();
        req_valid = 0; wb_en = 0;
        @(negedge clk);
        chk("pend_clear", pending, 8'h00);
        step();

        // Backpressure hold, then back-to-back transfer
        op_ready = 0;
        issue(3, 5, 0, 0, 16'h1234, 16'hBEEF);
        rs1_addr = 5; rs2_addr = 3; req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready", req_ready, 0);
            chk("hold_valid", op_valid, 1);
            chk("hold_ab", {op_a, op_b}, {16'h1234, 16'hBEEF});
            step();
        end
        op_ready = 1;
        @(negedge clk);
        chk("b2b_ready", req_ready, 1);
        if (req_ready) exp_q.push_back({16'hBEEF, 16'h1234});
        step();
        req_valid = 0;
        @(negedge clk);
        chk("b2b_valid", op_valid, 1);
        step();

        // R0 write ignored and never pending
        wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF;
        step();
        wb_en = 0;
        issue(0, 0, 0, 1, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("r0_pending", pending, 8'h00);
        step();

        // Asynchronous reset mid-operation
        op_ready = 0;
        issue(1, 1, 4, 1, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("pre_rst_pend", pending, 8'h10);
        chk("pre_rst_valid", op_valid, 1);
        step();
        #1;
        reset = 0;
        void'(exp_q.pop_back());
        #1;
        chk("mid_rst_valid", op_valid, 0);
        chk("mid_rst_pend", pending, 8'h00);
        chk("mid_rst_r3", dut.regs[3], 0);
        chk("mid_rst_r5", dut.regs[5], 0);
        step();
        reset = 1; op_ready = 1;
        step();
        issue(3, 5, 0, 0, 16'h0000, 16'h0000);
        step();
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
